// File: rtl/router_pkg.sv
// Shared definitions for the router input controller: header layout,
// FSM states, defaults and the address-to-select helper.
package router_pkg;

  localparam int DATA_W_DEFAULT  = 8;
  localparam int TIMEOUT_DEFAULT = 30;
  localparam int NUM_PORTS       = 3;

  // Header byte is {length[7:2], addr[1:0]}
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 2;
  localparam int LEN_LSB  = 2;
  localparam int LEN_W    = 6;

  // Length counter is one bit wider so length+1 (payload plus parity) fits
  localparam int CNT_W = LEN_W + 1;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    DECODE,
    WAIT_EMPTY,
    LOAD_FIRST,
    LOAD_DATA,
    LOAD_PARITY,
    CHECK_PARITY,
    DROP
  } state_t;

  // One-hot FIFO select; the invalid address selects nothing
  function automatic logic [NUM_PORTS-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
    logic [NUM_PORTS-1:0] sel;
    case (addr)
      2'd0:    sel = 3'b001;
      2'd1:    sel = 3'b010;
      2'd2:    sel = 3'b100;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/router_softrst_timer.sv
// Per-FIFO watchdog: pulses soft_reset when a FIFO holding data has gone
// unread for TIMEOUT consecutive cycles.
module router_softrst_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic vld,
  input  logic read,
  input  logic empty,
  output logic soft_reset
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  // The pulse fires during the TIMEOUT-th unread cycle itself
  assign soft_reset = vld && !read && !empty && (count == LAST);

  // Count unread cycles; any read, drain or fired pulse restarts the window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (read || empty || soft_reset) begin
      count <= '0;
    end else if (vld) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/router_pkt_ctrl.sv
// Input-side controller of the 1x3 router: decodes the header, steers
// bytes into the selected FIFO, checks parity and supervises read timeouts.
module router_pkt_ctrl
  import router_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [DATA_W-1:0]    data_in,
  output logic                 busy,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] read_enb,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 lfd_state,
  output logic [DATA_W-1:0]    data_to_fifo,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 parity_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   par;
  logic [DATA_W-1:0]   hold;

  logic [ADDR_W-1:0]    hdr_addr;
  logic [CNT_W-1:0]     hdr_len;
  logic [NUM_PORTS-1:0] hdr_sel;
  logic [NUM_PORTS-1:0] sel;
  logic                 tgt_full;
  logic                 tgt_empty;
  logic                 tgt_srst;
  logic                 accept;

  assign hdr_addr  = data_in[ADDR_LSB +: ADDR_W];
  assign hdr_len   = {1'b0, data_in[LEN_LSB +: LEN_W]};
  assign hdr_sel   = addr_onehot(hdr_addr);
  assign sel       = addr_onehot(addr);
  assign tgt_full  = |(fifo_full & sel);
  assign tgt_empty = |(fifo_empty & sel);
  assign tgt_srst  = |(soft_reset & sel);
  assign accept    = pkt_valid && !busy;
  assign vld_out   = ~fifo_empty;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_timer
      router_softrst_timer #(
        .TIMEOUT (TIMEOUT)
      ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .vld        (vld_out[gi]),
        .read       (read_enb[gi]),
        .empty      (fifo_empty[gi]),
        .soft_reset (soft_reset[gi])
      );
    end
  endgenerate

  // Source stall and FIFO write strobes; writes happen in the accepting cycle.
  // A firing soft reset stalls the source so the abort never races a byte.
  always_comb begin
    busy         = 1'b0;
    write_enb    = '0;
    lfd_state    = 1'b0;
    data_to_fifo = '0;
    case (state)
      DECODE:       busy = 1'b0;
      WAIT_EMPTY:   busy = 1'b1;
      LOAD_FIRST: begin
        busy = 1'b1;
        if (!tgt_full) begin
          write_enb    = sel;
          lfd_state    = 1'b1;
          data_to_fifo = hold;
        end
      end
      LOAD_DATA, LOAD_PARITY: begin
        busy = tgt_full || tgt_srst;
        if (pkt_valid && !(tgt_full || tgt_srst)) begin
          write_enb    = sel;
          data_to_fifo = data_in;
        end
      end
      CHECK_PARITY: busy = 1'b1;
      DROP:         busy = 1'b0;
      default:      busy = 1'b0;
    endcase
  end

  // Packet sequencer: header decode, payload count, parity accumulate/check
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= DECODE;
      addr       <= '0;
      cnt        <= '0;
      par        <= '0;
      hold       <= '0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      case (state)
        DECODE: begin
          if (accept) begin
            addr <= hdr_addr;
            cnt  <= hdr_len;
            par  <= data_in;
            hold <= data_in;
            if (hdr_addr == ADDR_INVALID) begin
              cnt   <= hdr_len + CNT_ONE;
              state <= DROP;
            end else if (|(fifo_empty & hdr_sel)) begin
              state <= LOAD_FIRST;
            end else begin
              state <= WAIT_EMPTY;
            end
          end
        end
        WAIT_EMPTY: begin
          if (tgt_empty) state <= LOAD_FIRST;
        end
        LOAD_FIRST: begin
          if (!tgt_full) state <= (cnt != '0) ? LOAD_DATA : LOAD_PARITY;
        end
        LOAD_DATA: begin
          if (tgt_srst) begin
            cnt   <= cnt + CNT_ONE;
            state <= DROP;
          end else if (accept) begin
            par <= par ^ data_in;
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) state <= LOAD_PARITY;
          end
        end
        LOAD_PARITY: begin
          if (tgt_srst) begin
            cnt   <= CNT_ONE;
            state <= DROP;
          end else if (accept) begin
            hold  <= data_in;
            state <= CHECK_PARITY;
          end
        end
        CHECK_PARITY: begin
          parity_err <= (par != hold);
          state      <= DECODE;
        end
        DROP: begin
          if (accept) begin
            cnt <= cnt - CNT_ONE;
            if (cnt <= CNT_ONE) state <= DECODE;
          end
        end
        default: state <= DECODE;
      endcase
    end
  end

endmodule
